// File: rtl/adder_pkg.sv
// Shared defaults and the operand record used by the adder issue stage.
// The operand FIFO stores one of these per entry.
package adder_pkg;

  localparam int DEF_WIDTH = 24;
  localparam int DEF_DEPTH = 4;

  localparam logic [7:0] CARRY_CNT_MAX = 8'd255;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
    logic                 c;
  } operand_t;

endpackage

// File: rtl/adder_fifo.sv
// Operand FIFO for the adder issue stage: DEPTH entries with a registered
// occupancy count. Pushes are ignored when full and pops when empty.
module adder_fifo
  import adder_pkg::*;
#(
  parameter int  DEPTH = DEF_DEPTH,
  parameter type T     = operand_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  T                         din,
  input  logic                     pop,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/adder_issue_stage.sv
// Issue stage in front of an external combinational adder: buffers operand
// triples, feeds the FIFO head to the adder and registers its result.
module adder_issue_stage
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic                     in_c,
  output logic [WIDTH-1:0]         a_in,
  output logic [WIDTH-1:0]         b_in,
  output logic                     c_in,
  input  logic [WIDTH-1:0]         sum,
  input  logic                     carry,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum,
  output logic                     out_carry,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               carry_cnt
);

  // Same layout as operand_t, but sized by this instance's WIDTH.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
  } op_t;

  op_t              din;
  op_t              head;
  logic             full;
  logic             empty;
  logic             pop;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_carry_q;
  logic [7:0]       carry_cnt_q;
  logic             deliver;

  assign din = '{a: in_a, b: in_b, c: in_c};

  adder_fifo #(
    .DEPTH (DEPTH),
    .T     (op_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // in_ready comes straight from the registered count, never from out_ready.
  assign in_ready = !full;

  assign a_in = empty ? '0 : head.a;
  assign b_in = empty ? '0 : head.b;
  assign c_in = empty ? 1'b0 : head.c;

  assign pop     = !empty && (!out_valid_q || out_ready);
  assign deliver = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_carry_q <= 1'b0;
    end else if (pop) begin
      out_valid_q <= 1'b1;
      out_sum_q   <= sum;
      out_carry_q <= carry;
    end else if (deliver) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_cnt_q <= '0;
    end else if (deliver && out_carry_q && (carry_cnt_q != CARRY_CNT_MAX)) begin
      carry_cnt_q <= carry_cnt_q + 8'd1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_carry = out_carry_q;
  assign carry_cnt = carry_cnt_q;

endmodule

// File: tb/tb_adder_issue_stage.sv
// Bench for adder_issue_stage: directed scenarios plus random traffic,
// checked by a scoreboard fed from the accepted operands.
module tb_adder_issue_stage;

  localparam int W = 24;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_c;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         c_in;
  logic [W-1:0] sum;
  logic         carry;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_carry;
  logic [2:0]   count;
  logic [7:0]   carry_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  // Stand-in for the external genericadder.
  assign {carry, sum} = {1'b0, a_in} + {1'b0, b_in} + {{W{1'b0}}, c_in};

  adder_issue_stage #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .sum       (sum),
    .carry     (carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .count     (count),
    .carry_cnt (carry_cnt)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n;
    n = 0;
    in_a = a; in_b = b; in_c = c; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      cyc();
      n++;
    end
    if (!in_ready) chk("push_timeout_in_ready", 32'(in_ready), 32'd1);
    cyc();
  endtask

  // Input-side monitor: occupancy/valid model and scoreboard fill.
  initial begin
    int         m_occ;
    logic       m_ov;
    logic       push;
    logic       pop;
    logic [W:0] e;
    m_occ = 0;
    m_ov  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_occ = 0;
        m_ov  = 1'b0;
      end else begin
        chk("count", 32'(count), 32'(m_occ));
        chk("in_ready", 32'(in_ready), 32'(m_occ != D));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        push = in_valid && (m_occ != D);
        pop  = (m_occ != 0) && (!m_ov || out_ready);
        if (push) begin
          e = {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_c};
          exp_q.push_back(e);
        end
        m_occ = m_occ + int'(push) - int'(pop);
        if (pop) m_ov = 1'b1;
        else if (m_ov && out_ready) m_ov = 1'b0;
      end
    end
  end

  // Output-side monitor: result order/value, stall stability, carry counter.
  initial begin
    int           m_cc;
    logic         stalled;
    logic [W-1:0] held_sum;
    logic         held_carry;
    logic [W:0]   e;
    m_cc    = 0;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_cc    = 0;
        stalled = 1'b0;
      end else begin
        chk("carry_cnt", 32'(carry_cnt), 32'(m_cc));
        if (stalled) begin
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_sum", 32'(out_sum), 32'(held_sum));
          chk("stall_carry", 32'(out_carry), 32'(held_carry));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result_sum", 32'(out_sum), 32'hDEAD_BEEF);
          end else begin
            e = exp_q.pop_front();
            chk("out_sum", 32'(out_sum), 32'(e[W-1:0]));
            chk("out_carry", 32'(out_carry), 32'(e[W]));
            if (e[W] && m_cc != 255) m_cc++;
          end
        end
        stalled    = out_valid && !out_ready;
        held_sum   = out_sum;
        held_carry = out_carry;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_c = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_carry_cnt", 32'(carry_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_a_in", 32'(a_in), 32'd0);
    cyc(); cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // Single op with a free output register
    out_ready = 1'b1;
    push_op(24'h000005, 24'h000003, 1'b1);
    in_valid = 1'b0;
    cyc();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_sum", 32'(out_sum), 32'h9);
    chk("single_carry", 32'(out_carry), 32'd0);
    cyc();
    chk("single_count", 32'(count), 32'd0);
    chk("single_drained", 32'(out_valid), 32'd0);

    // Carry-out
    push_op(24'hFFFFFF, 24'h000001, 1'b0);
    in_valid = 1'b0;
    cyc();
    chk("wrap_sum", 32'(out_sum), 32'd0);
    chk("wrap_carry", 32'(out_carry), 32'd1);
    cyc();
    chk("wrap_carry_cnt", 32'(carry_cnt), 32'd1);

    // Back-pressure until full, then drain
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_op(W'(32'h100 * (i + 1)), W'(i), 1'(i));
    in_valid = 1'b0;
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_a = 24'h123456; in_valid = 1'b1;
    cyc();
    cyc();
    chk("full_still_count", 32'(count), 32'd4);
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    chk("drain4_count", 32'(count), 32'd0);
    chk("drain4_valid", 32'(out_valid), 32'd1);
    cyc();
    chk("drain5_valid", 32'(out_valid), 32'd0);

    // Simultaneous push/pop at count 2
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_op(W'($urandom), W'($urandom), 1'($urandom));
    chk("pp_pre_count", 32'(count), 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_op(W'($urandom), W'($urandom), 1'($urandom));
      chk("pp_count", 32'(count), 32'd2);
    end
    in_valid = 1'b0;
    repeat (5) cyc();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom);
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_c      = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) cyc();

    // Carry counter saturation
    for (int i = 0; i < 260; i++) push_op(24'hFFFFFF, W'($urandom_range(1, 24'hFFFF)), 1'($urandom));
    in_valid = 1'b0;
    repeat (5) cyc();
    chk("sat_carry_cnt", 32'(carry_cnt), 32'd255);

    // Reset mid-operation
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_op(W'($urandom), W'($urandom), 1'($urandom));
    in_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_carry_cnt", 32'(carry_cnt), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_sum", 32'(out_sum), 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("post_rst_no_stale", 32'(out_valid), 32'd0);
    end
    push_op(24'h00000A, 24'h000014, 1'b0);
    in_valid = 1'b0;
    cyc();
    chk("post_rst_sum", 32'(out_sum), 32'h1E);
    repeat (3) cyc();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/adder_issue_stage.md
# adder_issue_stage

Sequential front-end for the combinational `genericadder`. It accepts operand triples (a, b, carry-in) over a valid/ready handshake and buffers them in a small FIFO. It presents the FIFO head to the adder, registers the adder's sum/carry into an output holding register, and hands the result downstream over a second valid/ready handshake. The block also keeps a saturating count of results that produced a carry-out.

## Interface
Parameters:
- WIDTH, 24, operand and sum width; must match the attached `genericadder`.
- DEPTH, 4, operand FIFO entries; power of two, at least 2.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  rising-edge clock.
  - rst_n  in  1  asynchronous active-low reset.
- Upstream operand interface:
  - in_valid  in  1  operand triple present.
  - in_ready  out  1  FIFO can accept; equals (count != DEPTH).
  - in_a  in  WIDTH  operand A.
  - in_b  in  WIDTH  operand B.
  - in_c  in  1  carry-in.
- Adder-side interface (to `genericadder`):
  - a_in  out  WIDTH  adder operand A; FIFO head when non-empty, else 0.
  - b_in  out  WIDTH  adder operand B; FIFO head when non-empty, else 0.
  - c_in  out  1  adder carry-in; FIFO head when non-empty, else 0.
  - sum  in  WIDTH  adder sum, combinational from a_in/b_in/c_in.
  - carry  in  1  adder carry-out, combinational.
- Downstream result interface:
  - out_valid  out  1  result register holds a result.
  - out_ready  in  1  consumer accepts the result.
  - out_sum  out  WIDTH  registered sum.
  - out_carry  out  1  registered carry-out.
- Status:
  - count  out  $clog2(DEPTH)+1  FIFO occupancy.
  - carry_cnt  out  8  saturating number of delivered results with carry = 1.

## Operation
- Push: in_valid && in_ready at a rising edge writes {in_a, in_b, in_c} at the write pointer; the write pointer increments modulo DEPTH.
- Pop: the pop condition is count != 0 && (!out_valid || out_ready). On a pop at a rising edge:
  - out_sum <= sum and out_carry <= carry;
  - out_valid <= 1;
  - the read pointer increments modulo DEPTH.
- Output drain: if out_valid && out_ready && no pop, then out_valid <= 0. out_sum and out_carry keep their last value.
- Stall: while out_valid && !out_ready, out_sum, out_carry and out_valid hold stable and no pop occurs.
- count update: next count = count + push − pop. A push and a pop in the same edge leave count unchanged.
- Full: at count == DEPTH, in_ready = 0. No push occurs that edge, even if a pop also occurs.
- Empty: at count == 0, a_in/b_in/c_in are driven to 0 and no pop occurs.
- Arithmetic: done entirely by the adder. WIDTH-bit sum plus 1-bit carry; no truncation or extension in this block.
- carry_cnt increments on each downstream handshake (out_valid && out_ready) where out_carry == 1. It saturates at 255.
- Reset (asserted at any time, including mid-transfer):
  - pointers, count, out_valid, out_sum, out_carry and carry_cnt go to 0 immediately;
  - FIFO contents are discarded;
  - in_ready reads 1 while rst_n is low and after release.

## Timing
- Latency: an operand accepted at edge E can appear on out_* after edge E+1, provided the output register is free. Minimum latency is 2 edges from in_valid assertion to out_valid.
- Throughput: one result per cycle while out_ready stays high and the FIFO is non-empty.
- Combinational paths:
  - in_ready depends only on the count register; there is no combinational path from out_ready.
  - The only intentional combinational path through this block is FIFO head → a_in/b_in/c_in → adder → sum/carry → result-register D inputs; this path must close in one cycle.

## Structure
- Package adder_pkg holds:
  - the WIDTH and DEPTH defaults;
  - typedef operand_t, a packed struct {a[WIDTH], b[WIDTH], c};
  - the CARRY_CNT_MAX constant (255).
- Sub-module adder_fifo: a DEPTH-entry operand_t FIFO with push/pop, head output, count, full and empty.
- The top level holds the result register, the pop logic and carry_cnt.
- `genericadder` is instantiated by the parent and is not inside this block.

## Test plan
- Single op, out_ready = 1: push a = 24'h000005, b = 24'h000003, c = 1. out_valid is high after edge E+1 with out_sum = 24'h000009 and out_carry = 0; count returns to 0.
- Carry-out: push a = 24'hFFFFFF, b = 24'h000001, c = 0. Result is out_sum = 0, out_carry = 1, and carry_cnt becomes 1 after the handshake.
- Back-pressure/full: hold out_ready = 0 and push 5 triples. One triple lands in the result register, four fill the FIFO, and in_ready = 0 with count = 4. Then raise out_ready: the five results drain in order, one per cycle.
- Simultaneous push/pop: keep the FIFO at count = 2 with in_valid = 1 and out_ready = 1 for 10 cycles. count stays at 2 and results emerge in push order.
- Saturation: deliver 260 results with carry = 1. carry_cnt stops at 255.
- Reset mid-operation: drop rst_n with count = 3 and out_valid = 1. out_valid, count and carry_cnt are 0 immediately, in_ready = 1, and no stale result appears after release.
